// File: rtl/vec_cache_dirty_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// vec_cache_dirty_ctrl_pkg
// Shared definitions for the vector-cache dirty-bit controller:
//   - default geometry (set index width, ways per set, update ports)
//   - flush engine state encoding
//   - dirty update request record used inside the array arbitration
//   - dirty counter width helper
// -----------------------------------------------------------------------------
package vec_cache_dirty_ctrl_pkg;

    localparam int DEF_INDEX_WIDTH = 8;
    localparam int DEF_WAY_NUM     = 8;
    localparam int DEF_PORT_NUM    = 2;

    // Flush engine states; the FSM mirrors these as plain logic constants.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } flush_state_e;

    // One update port's request, sized for the default cache geometry.
    typedef struct packed {
        logic                       set;
        logic                       clean;
        logic [DEF_INDEX_WIDTH-1:0] idx;
        logic [DEF_WAY_NUM-1:0]     way_oh;
    } dirty_upd_t;

    // Counter must hold the value "every line dirty", hence lines+1.
    function automatic int cnt_width(input int lines);
        return $clog2(lines + 1);
    endfunction

endpackage

// File: rtl/vec_cache_dirty_ctrl_if.sv
// -----------------------------------------------------------------------------
// vec_cache_dirty_ctrl_if
// Writeback request channel from the flush engine to the evict path.
//   wb_vld  : request valid (master -> slave)
//   wb_idx  : set index of the dirty line
//   wb_way  : binary way of the dirty line
//   wb_rdy  : request accepted (slave -> master)
// A transfer happens on every clock edge where wb_vld and wb_rdy are both high.
// -----------------------------------------------------------------------------
interface vec_cache_dirty_ctrl_if #(
    parameter int INDEX_WIDTH = 8,
    parameter int WAY_NUM     = 8
);
    localparam int WAY_W = $clog2(WAY_NUM);

    logic                   wb_vld;
    logic [INDEX_WIDTH-1:0] wb_idx;
    logic [WAY_W-1:0]       wb_way;
    logic                   wb_rdy;

    modport master (
        output wb_vld,
        output wb_idx,
        output wb_way,
        input  wb_rdy
    );

    modport slave (
        input  wb_vld,
        input  wb_idx,
        input  wb_way,
        output wb_rdy
    );

endinterface

// File: rtl/vec_cache_dirty_ctrl_flush_fsm.sv
// -----------------------------------------------------------------------------
// vec_cache_dirty_ctrl_flush_fsm
// Flush engine: walks the dirty array one set per cycle and issues one
// writeback request per dirty line, lowest way first.
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_flush_req    : start pulse, honoured only while idle
//   i_tag_dirty    : registered dirty array (already reflects past handshakes)
//   i_wb_rdy       : writeback accepted
//   o_wb_vld/idx/way : registered writeback request
//   o_flush_busy   : high from the cycle after acceptance until the engine
//                    returns to idle
//   o_flush_done   : one-cycle completion pulse
// After a handshake the same set is rescanned, because the array has
// already dropped the issued bit by then; remaining ways (or a way that was
// re-dirtied in the handshake cycle) are therefore issued in turn.
// -----------------------------------------------------------------------------
module vec_cache_dirty_ctrl_flush_fsm
    import vec_cache_dirty_ctrl_pkg::*;
#(
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int WAY_NUM     = DEF_WAY_NUM,
    localparam int SET_NUM    = 2 ** INDEX_WIDTH,
    localparam int WAY_W      = $clog2(WAY_NUM)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_flush_req,
    input  logic [SET_NUM-1:0][WAY_NUM-1:0]    i_tag_dirty,
    input  logic                               i_wb_rdy,
    output logic                               o_wb_vld,
    output logic [INDEX_WIDTH-1:0]             o_wb_idx,
    output logic [WAY_W-1:0]                   o_wb_way,
    output logic                               o_flush_busy,
    output logic                               o_flush_done
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SCAN  = SCAN;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_DONE  = DONE;

    localparam logic [INDEX_WIDTH-1:0] LAST_SET = {INDEX_WIDTH{1'b1}};

    // Lowest set bit of a dirty row, as a binary way number.
    function automatic logic [WAY_W-1:0] lowest_way(input logic [WAY_NUM-1:0] row);
        logic [WAY_W-1:0] v_way;
        v_way = '0;
        for (int k = WAY_NUM - 1; k >= 0; k--) begin
            if (row[k]) begin
                v_way = WAY_W'(k);
            end else begin
                v_way = v_way;
            end
        end
        return v_way;
    endfunction

    logic [1:0]             r_state;
    logic [INDEX_WIDTH-1:0] r_ptr;
    logic                   r_wb_vld;
    logic [INDEX_WIDTH-1:0] r_wb_idx;
    logic [WAY_W-1:0]       r_wb_way;
    logic                   r_busy;
    logic                   r_done;

    logic [WAY_NUM-1:0]     w_row;
    logic [WAY_W-1:0]       w_low_way;

    assign w_row     = i_tag_dirty[r_ptr];
    assign w_low_way = lowest_way(w_row);

    // Flush state machine, scan pointer and writeback request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_wb_vld <= 1'b0;
            r_wb_idx <= '0;
            r_wb_way <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_flush_req) begin
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (|w_row) begin
                        r_wb_idx <= r_ptr;
                        r_wb_way <= w_low_way;
                        r_wb_vld <= 1'b1;
                        r_state  <= ST_ISSUE;
                    end else if (r_ptr == LAST_SET) begin
                        // Pulse is visible during the DONE cycle.
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_ptr <= r_ptr + {{(INDEX_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                ST_ISSUE: begin
                    // Request stays up, unchanged, until it is taken.
                    if (i_wb_rdy) begin
                        r_wb_vld <= 1'b0;
                        r_state  <= ST_SCAN;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_wb_vld <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

    assign o_wb_vld     = r_wb_vld;
    assign o_wb_idx     = r_wb_idx;
    assign o_wb_way     = r_wb_way;
    assign o_flush_busy = r_busy;
    assign o_flush_done = r_done;

endmodule

// File: rtl/vec_cache_dirty_ctrl.sv
// -----------------------------------------------------------------------------
// vec_cache_dirty_ctrl
// Dirty-bit array for the vector cache tag pipeline with PORT_NUM update
// ports, a live dirty-line counter and a flush engine.
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_upd_set[p]      : port p marks (i_upd_idx[p], i_upd_way_oh[p]) dirty
//   i_upd_clean[p]    : port p marks the same line clean (set wins)
//   i_upd_idx[p]      : port p set index
//   i_upd_way_oh[p]   : port p way, one-hot or zero
//   i_rd_idx          : lookup index for o_rd_dirty
//   o_rd_dirty        : dirty vector of i_rd_idx, combinational from state
//   o_tag_dirty       : full registered array
//   o_dirty_cnt       : registered number of dirty lines
//   i_flush_req       : start a flush (ignored while one is running)
//   o_flush_busy      : flush in progress
//   o_flush_done      : one-cycle completion pulse
//   wb_if             : writeback request channel (master side)
// Per bit: any matching set makes it 1; otherwise a matching clean or a
// writeback handshake on that line makes it 0; otherwise it holds.
// -----------------------------------------------------------------------------
module vec_cache_dirty_ctrl
    import vec_cache_dirty_ctrl_pkg::*;
#(
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int WAY_NUM     = DEF_WAY_NUM,
    parameter int PORT_NUM    = DEF_PORT_NUM,
    localparam int SET_NUM    = 2 ** INDEX_WIDTH,
    localparam int WAY_W      = $clog2(WAY_NUM),
    localparam int CNT_W      = cnt_width(SET_NUM * WAY_NUM)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [PORT_NUM-1:0]                   i_upd_set,
    input  logic [PORT_NUM-1:0]                   i_upd_clean,
    input  logic [PORT_NUM-1:0][INDEX_WIDTH-1:0]  i_upd_idx,
    input  logic [PORT_NUM-1:0][WAY_NUM-1:0]      i_upd_way_oh,
    input  logic [INDEX_WIDTH-1:0]                i_rd_idx,
    output logic [WAY_NUM-1:0]                    o_rd_dirty,
    output logic [SET_NUM-1:0][WAY_NUM-1:0]       o_tag_dirty,
    output logic [CNT_W-1:0]                      o_dirty_cnt,
    input  logic                                  i_flush_req,
    output logic                                  o_flush_busy,
    output logic                                  o_flush_done,
    vec_cache_dirty_ctrl_if.master                wb_if
);

    logic [SET_NUM-1:0][WAY_NUM-1:0]      r_tag_dirty;
    logic [SET_NUM-1:0][WAY_NUM-1:0]      w_tag_next;
    logic [CNT_W-1:0]                     r_dirty_cnt;
    logic [CNT_W-1:0]                     w_inc;
    logic [CNT_W-1:0]                     w_dec;

    dirty_upd_t [PORT_NUM-1:0]            w_upd;
    logic [PORT_NUM-1:0]                  w_p_set;
    logic [PORT_NUM-1:0]                  w_p_clean;
    logic [PORT_NUM-1:0]                  w_p_act;
    logic [PORT_NUM-1:0][INDEX_WIDTH-1:0] w_p_idx;
    logic [PORT_NUM-1:0][WAY_NUM-1:0]     w_p_oh;

    logic                                 w_wb_vld;
    logic [INDEX_WIDTH-1:0]               w_wb_idx;
    logic [WAY_W-1:0]                     w_wb_way;
    logic                                 w_wb_hs;

    // Collect each port's strobes into one request record, then unpack the
    // fields at the array geometry.
    always_comb begin
        for (int p = 0; p < PORT_NUM; p++) begin
            w_upd[p].set    = i_upd_set[p];
            w_upd[p].clean  = i_upd_clean[p];
            w_upd[p].idx    = $bits(w_upd[p].idx)'(i_upd_idx[p]);
            w_upd[p].way_oh = $bits(w_upd[p].way_oh)'(i_upd_way_oh[p]);
            w_p_set[p]      = w_upd[p].set;
            w_p_clean[p]    = w_upd[p].clean;
            w_p_idx[p]      = INDEX_WIDTH'(w_upd[p].idx);
            w_p_oh[p]       = WAY_NUM'(w_upd[p].way_oh);
            // A port only touches the array when it names a way.
            w_p_act[p]      = (w_upd[p].set | w_upd[p].clean) & (|w_upd[p].way_oh);
        end
    end

    assign w_wb_hs = w_wb_vld & wb_if.wb_rdy;

    // Next array state: set beats clean, clean or handshake beats hold.
    always_comb begin
        logic v_set;
        logic v_clr;
        w_tag_next = r_tag_dirty;
        for (int i = 0; i < SET_NUM; i++) begin
            for (int j = 0; j < WAY_NUM; j++) begin
                v_set = 1'b0;
                v_clr = w_wb_hs && (w_wb_idx == INDEX_WIDTH'(i)) && (w_wb_way == WAY_W'(j));
                for (int p = 0; p < PORT_NUM; p++) begin
                    if ((w_p_idx[p] == INDEX_WIDTH'(i)) && w_p_oh[p][j]) begin
                        v_set = v_set | w_p_set[p];
                        v_clr = v_clr | w_p_clean[p];
                    end else begin
                        v_set = v_set;
                    end
                end
                if (v_set) begin
                    w_tag_next[i][j] = 1'b1;
                end else if (v_clr) begin
                    w_tag_next[i][j] = 1'b0;
                end else begin
                    w_tag_next[i][j] = r_tag_dirty[i][j];
                end
            end
        end
    end

    // Counter adjust: one term per port plus the writeback handshake. A term
    // counts only if its bit really flips and no earlier term names the same
    // bit, so duplicates and no-op updates contribute nothing.
    always_comb begin
        logic v_dup;
        logic v_cur;
        logic v_nxt;
        w_inc = '0;
        w_dec = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            v_dup = 1'b0;
            for (int q = 0; q < PORT_NUM; q++) begin
                if ((q < p) && w_p_act[q] && (w_p_idx[q] == w_p_idx[p]) &&
                    (|(w_p_oh[q] & w_p_oh[p]))) begin
                    v_dup = 1'b1;
                end else begin
                    v_dup = v_dup;
                end
            end
            v_cur = |(r_tag_dirty[w_p_idx[p]] & w_p_oh[p]);
            v_nxt = |(w_tag_next[w_p_idx[p]] & w_p_oh[p]);
            if (w_p_act[p] && !v_dup && (v_cur != v_nxt)) begin
                if (v_nxt) begin
                    w_inc = w_inc + CNT_W'(1);
                end else begin
                    w_dec = w_dec + CNT_W'(1);
                end
            end else begin
                w_inc = w_inc;
            end
        end
        // Handshake term, skipped when a port already accounts for that bit.
        v_dup = 1'b0;
        for (int p = 0; p < PORT_NUM; p++) begin
            if (w_p_act[p] && (w_p_idx[p] == w_wb_idx) && w_p_oh[p][w_wb_way]) begin
                v_dup = 1'b1;
            end else begin
                v_dup = v_dup;
            end
        end
        v_cur = r_tag_dirty[w_wb_idx][w_wb_way];
        v_nxt = w_tag_next[w_wb_idx][w_wb_way];
        if (w_wb_hs && !v_dup && v_cur && !v_nxt) begin
            w_dec = w_dec + CNT_W'(1);
        end else begin
            w_dec = w_dec;
        end
    end

    // Dirty array register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_dirty <= '0;
        end else begin
            r_tag_dirty <= w_tag_next;
        end
    end

    // Dirty line counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dirty_cnt <= '0;
        end else begin
            r_dirty_cnt <= r_dirty_cnt + w_inc - w_dec;
        end
    end

    vec_cache_dirty_ctrl_flush_fsm #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .WAY_NUM     (WAY_NUM)
    ) u_flush_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush_req  (i_flush_req),
        .i_tag_dirty  (r_tag_dirty),
        .i_wb_rdy     (wb_if.wb_rdy),
        .o_wb_vld     (w_wb_vld),
        .o_wb_idx     (w_wb_idx),
        .o_wb_way     (w_wb_way),
        .o_flush_busy (o_flush_busy),
        .o_flush_done (o_flush_done)
    );

    assign wb_if.wb_vld = w_wb_vld;
    assign wb_if.wb_idx = w_wb_idx;
    assign wb_if.wb_way = w_wb_way;

    assign o_rd_dirty  = r_tag_dirty[i_rd_idx];
    assign o_tag_dirty = r_tag_dirty;
    assign o_dirty_cnt = r_dirty_cnt;

endmodule

// File: tb/tb_vec_cache_dirty_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vec_cache_dirty_ctrl
// Directed bench for vec_cache_dirty_ctrl at the default geometry
// (256 sets, 8 ways, 2 update ports). Inputs change 1 ns after a rising
// edge; outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_vec_cache_dirty_ctrl;

    localparam int IW = 8;
    localparam int WN = 8;
    localparam int PN = 2;

    logic                       clk;
    logic                       rst_n;
    logic [PN-1:0]              upd_set;
    logic [PN-1:0]              upd_clean;
    logic [PN-1:0][IW-1:0]      upd_idx;
    logic [PN-1:0][WN-1:0]      upd_way_oh;
    logic [IW-1:0]              rd_idx;
    logic [WN-1:0]              rd_dirty;
    logic [255:0][WN-1:0]       tag_dirty;
    logic [11:0]                dirty_cnt;
    logic                       flush_req;
    logic                       flush_busy;
    logic                       flush_done;

    int n_checks;
    int n_errors;

    vec_cache_dirty_ctrl_if #(.INDEX_WIDTH(IW), .WAY_NUM(WN)) wb_bus ();

    vec_cache_dirty_ctrl #(
        .INDEX_WIDTH (IW),
        .WAY_NUM     (WN),
        .PORT_NUM    (PN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_upd_set    (upd_set),
        .i_upd_clean  (upd_clean),
        .i_upd_idx    (upd_idx),
        .i_upd_way_oh (upd_way_oh),
        .i_rd_idx     (rd_idx),
        .o_rd_dirty   (rd_dirty),
        .o_tag_dirty  (tag_dirty),
        .o_dirty_cnt  (dirty_cnt),
        .i_flush_req  (flush_req),
        .o_flush_busy (flush_busy),
        .o_flush_done (flush_done),
        .wb_if        (wb_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input int p, input logic s, input logic c,
                       input logic [IW-1:0] idx, input logic [WN-1:0] oh);
        upd_set[p]    = s;
        upd_clean[p]  = c;
        upd_idx[p]    = idx;
        upd_way_oh[p] = oh;
    endtask

    task automatic upd_clear();
        upd_set    = '0;
        upd_clean  = '0;
        upd_idx    = '0;
        upd_way_oh = '0;
    endtask

    initial begin
        logic [IW-1:0] rec_idx [4];
        logic [2:0]    rec_way [4];
        int            n_rec;
        int            n_done;
        int            n_vld;
        int            n;

        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        flush_req = 1'b0;
        rd_idx = 8'd0;
        wb_bus.wb_rdy = 1'b0;
        upd_clear();
        for (int k = 0; k < 4; k++) begin
            rec_idx[k] = 8'hff;
            rec_way[k] = 3'd7;
        end

        // ---- reset state
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk_val("rst_tag_any", 64'(|tag_dirty), 64'd0);
        chk_val("rst_cnt", 64'(dirty_cnt), 64'd0);
        chk_val("rst_busy", 64'(flush_busy), 64'd0);
        chk_val("rst_done", 64'(flush_done), 64'd0);
        chk_val("rst_wb_vld", 64'(wb_bus.wb_vld), 64'd0);

        // ---- single port set
        upd(0, 1'b1, 1'b0, 8'd5, 8'h04);
        tick();
        upd_clear();
        chk_val("set_tag5", 64'(tag_dirty[5]), 64'h04);
        chk_val("set_cnt", 64'(dirty_cnt), 64'd1);
        rd_idx = 8'd5;
        #1;
        chk_val("set_rd5", 64'(rd_dirty), 64'h04);

        // ---- clean on one port, set on the other, same bit already dirty
        upd(1, 1'b1, 1'b0, 8'd3, 8'h02);
        tick();
        chk_val("pre_cnt", 64'(dirty_cnt), 64'd2);
        upd(0, 1'b0, 1'b1, 8'd3, 8'h02);
        tick();
        upd_clear();
        chk_val("setwin_tag3", 64'(tag_dirty[3]), 64'h02);
        chk_val("setwin_cnt", 64'(dirty_cnt), 64'd2);

        // ---- both ports set the same clean bit: counts once
        upd(0, 1'b1, 1'b0, 8'd7, 8'h01);
        upd(1, 1'b1, 1'b0, 8'd7, 8'h01);
        tick();
        chk_val("dup_set_tag7", 64'(tag_dirty[7]), 64'h01);
        chk_val("dup_set_cnt", 64'(dirty_cnt), 64'd3);
        // both ports clean it: counts once
        upd(0, 1'b0, 1'b1, 8'd7, 8'h01);
        upd(1, 1'b0, 1'b1, 8'd7, 8'h01);
        tick();
        upd_clear();
        chk_val("dup_clr_tag7", 64'(tag_dirty[7]), 64'h00);
        chk_val("dup_clr_cnt", 64'(dirty_cnt), 64'd2);

        // ---- set and clean on one port: set wins
        upd(0, 1'b1, 1'b1, 8'd9, 8'h80);
        tick();
        upd_clear();
        chk_val("sc_tag9", 64'(tag_dirty[9]), 64'h80);
        chk_val("sc_cnt", 64'(dirty_cnt), 64'd3);

        // ---- clean everything; re-clean of a clean bit must not count
        upd(0, 1'b0, 1'b1, 8'd5, 8'h04);
        upd(1, 1'b0, 1'b1, 8'd3, 8'h02);
        tick();
        upd(0, 1'b0, 1'b1, 8'd9, 8'h80);
        upd(1, 1'b0, 1'b1, 8'd9, 8'h01);
        tick();
        upd_clear();
        chk_val("clean_all_cnt", 64'(dirty_cnt), 64'd0);
        chk_val("clean_all_tag", 64'(|tag_dirty), 64'd0);

        // ---- flush with wb_rdy held high
        upd(0, 1'b1, 1'b0, 8'd0, 8'h04);
        upd(1, 1'b1, 1'b0, 8'd0, 8'h40);
        tick();
        upd(0, 1'b1, 1'b0, 8'd255, 8'h01);
        upd(1, 1'b0, 1'b0, 8'd0, 8'h00);
        tick();
        upd_clear();
        chk_val("fl_pre_cnt", 64'(dirty_cnt), 64'd3);
        wb_bus.wb_rdy = 1'b1;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        chk_val("fl_busy", 64'(flush_busy), 64'd1);
        n_rec = 0;
        n_done = 0;
        for (int c = 0; c < 1000 && n_done == 0; c++) begin
            if (wb_bus.wb_vld) begin
                if (n_rec < 4) begin
                    rec_idx[n_rec] = wb_bus.wb_idx;
                    rec_way[n_rec] = wb_bus.wb_way;
                end
                n_rec++;
            end
            if (flush_done) n_done++;
            tick();
        end
        chk_val("fl_done_seen", 64'(n_done), 64'd1);
        chk_val("fl_nreq", 64'(n_rec), 64'd3);
        chk_val("fl_req0", {48'd0, rec_idx[0], 5'd0, rec_way[0]}, {48'd0, 8'd0, 5'd0, 3'd2});
        chk_val("fl_req1", {48'd0, rec_idx[1], 5'd0, rec_way[1]}, {48'd0, 8'd0, 5'd0, 3'd6});
        chk_val("fl_req2", {48'd0, rec_idx[2], 5'd0, rec_way[2]}, {48'd0, 8'd255, 5'd0, 3'd0});
        chk_val("fl_post_cnt", 64'(dirty_cnt), 64'd0);
        chk_val("fl_post_busy", 64'(flush_busy), 64'd0);
        for (int c = 0; c < 5; c++) begin
            if (flush_done) n_done++;
            tick();
        end
        chk_val("fl_done_once", 64'(n_done), 64'd1);

        // ---- backpressure on (10, way 3)
        wb_bus.wb_rdy = 1'b0;
        upd(0, 1'b1, 1'b0, 8'd10, 8'h08);
        tick();
        upd_clear();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        n = 0;
        while (!wb_bus.wb_vld && n < 50) begin
            tick();
            n++;
        end
        chk_val("bp_vld_seen", 64'(wb_bus.wb_vld), 64'd1);
        for (int c = 0; c < 5; c++) begin
            chk_val("bp_hold", {52'd0, wb_bus.wb_vld, wb_bus.wb_idx, wb_bus.wb_way},
                    {52'd0, 1'b1, 8'd10, 3'd3});
            tick();
        end
        // handshake cycle with a concurrent re-set of the issued bit
        wb_bus.wb_rdy = 1'b1;
        upd(1, 1'b1, 1'b0, 8'd10, 8'h08);
        tick();
        wb_bus.wb_rdy = 1'b0;
        upd_clear();
        chk_val("bp_reset_tag10", 64'(tag_dirty[10]), 64'h08);
        chk_val("bp_reset_cnt", 64'(dirty_cnt), 64'd1);
        n = 0;
        while (!wb_bus.wb_vld && n < 5) begin
            tick();
            n++;
        end
        chk_val("bp_reissue", {52'd0, wb_bus.wb_vld, wb_bus.wb_idx, wb_bus.wb_way},
                {52'd0, 1'b1, 8'd10, 3'd3});
        // port clean of the pending line does not withdraw the request
        upd(0, 1'b0, 1'b1, 8'd10, 8'h08);
        tick();
        upd_clear();
        chk_val("bp_cln_vld", 64'(wb_bus.wb_vld), 64'd1);
        chk_val("bp_cln_cnt", 64'(dirty_cnt), 64'd0);
        wb_bus.wb_rdy = 1'b1;
        tick();
        chk_val("bp_hs_cnt", 64'(dirty_cnt), 64'd0);
        n = 0;
        while (!flush_done && n < 300) begin
            tick();
            n++;
        end
        chk_val("bp_done_seen", 64'(flush_done), 64'd1);
        tick();

        // ---- reset in the middle of a scan
        upd(0, 1'b1, 1'b0, 8'd200, 8'h10);
        tick();
        upd_clear();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (5) tick();
        chk_val("mr_busy_before", 64'(flush_busy), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_val("mr_busy", 64'(flush_busy), 64'd0);
        chk_val("mr_vld", 64'(wb_bus.wb_vld), 64'd0);
        chk_val("mr_cnt", 64'(dirty_cnt), 64'd0);
        chk_val("mr_tag", 64'(|tag_dirty), 64'd0);
        chk_val("mr_done", 64'(flush_done), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        n_done = 0;
        n_vld = 0;
        for (int c = 0; c < 300; c++) begin
            if (flush_done) n_done++;
            if (wb_bus.wb_vld) n_vld++;
            tick();
        end
        chk_val("mr_no_done", 64'(n_done), 64'd0);
        chk_val("mr_no_vld", 64'(n_vld), 64'd0);
        chk_val("mr_idle_busy", 64'(flush_busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
